// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic {
        BR_ABS = 1'b0,
        BR_REL = 1'b1
    } br_mode_e;

    localparam int D         = 10;
    localparam int W         = 9;
    localparam int L         = 16;
    localparam int HALT_ADDR = 356;
    localparam int CW        = 16;

endpackage

// File: rtl/branch_lut.sv
// Run-time writable branch-target table; resolves absolute or PC-relative targets.
// Latency: combinational read (old entry on same-cycle write), write lands on the edge.
// Backpressure: none; writes are accepted every cycle regardless of pipeline state.
module branch_lut #(
    parameter int D  = fetch_pkg::D,
    parameter int L  = fetch_pkg::L,
    parameter int LW = $clog2(fetch_pkg::L)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [LW-1:0] widx,
    input  logic [D-1:0]  wdata,
    input  logic [LW-1:0] rd_idx,
    input  logic          mode,
    input  logic [D-1:0]  pc,
    output logic [D-1:0]  target
);
    import fetch_pkg::*;

    logic [D-1:0] lut [L];
    logic [D-1:0] entry;

    // Table storage: cleared on reset, one entry written per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                lut[i] <= '0;
            end
        end else if (we) begin
            lut[widx] <= wdata;
        end
    end

    // Target select; a D-bit wrapping add is the sign-extended relative offset.
    always_comb begin
        entry  = lut[rd_idx];
        target = entry;
        if (mode == BR_REL) begin
            target = pc + entry;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, branch redirect via LUT, one-entry fetch/decode register, halt.
// Latency: PC->mach_code 1 cycle; taken branch redirects next cycle with one bubble.
// Backpressure: stall holds PC, mach_code, mach_valid and issued; done freezes until reset.
module fetch_stage #(
    parameter int D         = fetch_pkg::D,
    parameter int W         = fetch_pkg::W,
    parameter int L         = fetch_pkg::L,
    parameter int HALT_ADDR = fetch_pkg::HALT_ADDR,
    parameter int CW        = fetch_pkg::CW,
    localparam int LW       = $clog2(L)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [D-1:0]  fetch_addr,
    input  logic [W-1:0]  rom_data,
    output logic [W-1:0]  mach_code,
    output logic          mach_valid,
    input  logic          stall,
    input  logic          br_take,
    input  logic          br_mode,
    input  logic [LW-1:0] br_idx,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_widx,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  prog_ctr,
    output logic [CW-1:0] issued,
    output logic          done
);
    import fetch_pkg::*;

    localparam logic [D-1:0] HALT_PC = D'(HALT_ADDR);

    logic [D-1:0] br_target;
    logic         halt_hit;
    logic         freeze;
    logic         advance;

    branch_lut #(
        .D  (D),
        .L  (L),
        .LW (LW)
    ) u_lut (
        .clk    (clk),
        .reset  (reset),
        .we     (lut_we),
        .widx   (lut_widx),
        .wdata  (lut_wdata),
        .rd_idx (br_idx),
        .mode   (br_mode),
        .pc     (prog_ctr),
        .target (br_target)
    );

    assign fetch_addr = prog_ctr;

    // Halt takes effect on the edge that sees HALT_PC, so the PC never steps past it.
    always_comb begin
        halt_hit = (prog_ctr == HALT_PC);
        freeze   = done || halt_hit;
        advance  = !freeze && !stall;
    end

    // Program counter: redirect on a taken branch, otherwise step with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_ctr <= '0;
        end else if (advance) begin
            prog_ctr <= br_take ? br_target : prog_ctr + D'(1);
        end
    end

    // Fetch/decode register; the word fetched alongside a taken branch is wrong-path.
    always_ff @(posedge clk) begin
        if (reset) begin
            mach_code  <= '0;
            mach_valid <= 1'b0;
        end else if (freeze) begin
            mach_valid <= 1'b0;
        end else if (!stall) begin
            mach_code  <= rom_data;
            mach_valid <= !br_take;
        end
    end

    // Issued count: an instruction is consumed when valid and not held by stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued <= '0;
        end else if (!done && !stall && mach_valid) begin
            issued <= issued + CW'(1);
        end
    end

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else if (halt_hit) begin
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic.
// Latency: expected values come from a per-cycle behavioural model of the fetch rules.
// Backpressure: stall is exercised both directed and at random.
module tb_fetch_stage;

    localparam int D    = 10;
    localparam int W    = 9;
    localparam int L    = 16;
    localparam int LW   = 4;
    localparam int HALT = 356;
    localparam int CW   = 16;
    localparam int PCM  = 1 << D;

    logic          clk = 1'b0;
    logic          reset;
    logic [D-1:0]  fetch_addr;
    logic [W-1:0]  rom_data;
    logic [W-1:0]  mach_code;
    logic          mach_valid;
    logic          stall;
    logic          br_take;
    logic          br_mode;
    logic [LW-1:0] br_idx;
    logic          lut_we;
    logic [LW-1:0] lut_widx;
    logic [D-1:0]  lut_wdata;
    logic [D-1:0]  prog_ctr;
    logic [CW-1:0] issued;
    logic          done;

    logic [W-1:0]  rom [PCM];

    always #5 clk = ~clk;

    assign rom_data = rom[fetch_addr];

    fetch_stage #(
        .D(D), .W(W), .L(L), .HALT_ADDR(HALT), .CW(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_addr (fetch_addr),
        .rom_data   (rom_data),
        .mach_code  (mach_code),
        .mach_valid (mach_valid),
        .stall      (stall),
        .br_take    (br_take),
        .br_mode    (br_mode),
        .br_idx     (br_idx),
        .lut_we     (lut_we),
        .lut_widx   (lut_widx),
        .lut_wdata  (lut_wdata),
        .prog_ctr   (prog_ctr),
        .issued     (issued),
        .done       (done)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state, plain integers.
    int m_pc, m_code, m_valid, m_issued, m_done;
    int m_lut [L];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, advance the model, check #1 after posedge.
    task automatic cyc(input logic rst, input logic st, input logic br, input logic md,
                       input int idx, input logic we, input int widx, input int wdata);
        int tgt;
        @(negedge clk);
        reset     = rst;
        stall     = st;
        br_take   = br;
        br_mode   = md;
        br_idx    = LW'(idx);
        lut_we    = we;
        lut_widx  = LW'(widx);
        lut_wdata = D'(wdata);
        if (rst) begin
            m_pc = 0; m_code = 0; m_valid = 0; m_issued = 0; m_done = 0;
            for (int i = 0; i < L; i++) m_lut[i] = 0;
        end else begin
            tgt = md ? (m_pc + m_lut[idx]) % PCM : m_lut[idx];
            if (we) m_lut[widx] = wdata;
            if (m_done != 0) begin
                m_valid = 0;
            end else if (m_pc == HALT) begin
                if (m_valid != 0 && !st) m_issued = (m_issued + 1) % (1 << CW);
                m_done  = 1;
                m_valid = 0;
            end else if (!st) begin
                if (m_valid != 0) m_issued = (m_issued + 1) % (1 << CW);
                m_code = int'(rom[m_pc]);
                if (br) begin
                    m_pc    = tgt;
                    m_valid = 0;
                end else begin
                    m_pc    = (m_pc + 1) % PCM;
                    m_valid = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("pc", 32'(prog_ctr), m_pc);
        chk("fetch_addr", 32'(fetch_addr), m_pc);
        chk("valid", 32'(mach_valid), m_valid);
        if (m_valid != 0) chk("code", 32'(mach_code), m_code);
        chk("issued", 32'(issued), m_issued);
        chk("done", 32'(done), m_done);
    endtask

    task automatic seq();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic lutw(input int widx, input int wdata);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, widx, wdata);
    endtask

    task automatic brn(input logic md, input int idx);
        cyc(1'b0, 1'b0, 1'b1, md, idx, 1'b0, 0, 0);
    endtask

    initial begin
        int p, c, iss;
        for (int i = 0; i < PCM; i++) rom[i] = W'(i);
        reset = 1'b1; stall = 1'b0; br_take = 1'b0; br_mode = 1'b0;
        br_idx = '0; lut_we = 1'b0; lut_widx = '0; lut_wdata = '0;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        chk("rst_pc", 32'(prog_ctr), 0);
        chk("rst_valid", 32'(mach_valid), 0);
        chk("rst_issued", 32'(issued), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_code", 32'(mach_code), 0);

        // Free run
        for (int k = 1; k <= 5; k++) begin
            seq();
            chk("fr_code", 32'(mach_code), k - 1);
            chk("fr_valid", 32'(mach_valid), 1);
        end
        chk("fr_issued", 32'(issued), 4);

        // Absolute branch through lut[3]
        lutw(3, 100);
        seq();
        chk("pc7", 32'(prog_ctr), 7);
        brn(1'b0, 3);
        chk("abs_pc", 32'(prog_ctr), 100);
        chk("abs_bubble", 32'(mach_valid), 0);
        seq();
        chk("abs_code", 32'(mach_code), 100);
        chk("abs_valid", 32'(mach_valid), 1);

        // Relative branch with negative offset, including wrap below zero
        lutw(2, 'h3FC);
        lutw(4, 20);
        brn(1'b0, 4);
        chk("pc20", 32'(prog_ctr), 20);
        brn(1'b1, 2);
        chk("rel_pc", 32'(prog_ctr), 16);
        lutw(6, 2);
        brn(1'b0, 6);
        chk("pc2", 32'(prog_ctr), 2);
        brn(1'b1, 2);
        chk("rel_wrap", 32'(prog_ctr), 1022);
        seq();
        seq();
        chk("seq_wrap", 32'(prog_ctr), 0);

        // Stall with a pending branch
        p = int'(prog_ctr); c = int'(mach_code); iss = int'(issued);
        repeat (3) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b0, 0, 0);
            chk("stall_pc", 32'(prog_ctr), p);
            chk("stall_code", 32'(mach_code), c);
            chk("stall_issued", 32'(issued), iss);
        end
        brn(1'b0, 3);
        chk("unstall_pc", 32'(prog_ctr), 100);
        chk("unstall_issued", 32'(issued), iss + 1);

        // Read-before-write on the same index
        lutw(5, 50);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 5, 1'b1, 5, 200);
        chk("rbw_old", 32'(prog_ctr), 50);
        brn(1'b0, 5);
        chk("rbw_new", 32'(prog_ctr), 200);

        // Randomized traffic against the model
        repeat (600) begin
            cyc(($urandom % 97) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
                1'($urandom % 2), int'($urandom % L), ($urandom % 3) == 0,
                int'($urandom % L), int'($urandom % PCM));
        end

        // Run to the halt address
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        lutw(1, 353);
        brn(1'b0, 1);
        chk("pc353", 32'(prog_ctr), 353);
        for (int n = 0; n < 10 && prog_ctr != D'(HALT); n++) seq();
        chk("reach_halt", 32'(prog_ctr), HALT);
        chk("pre_done", 32'(done), 0);
        seq();
        chk("done_set", 32'(done), 1);
        chk("done_pc", 32'(prog_ctr), HALT);
        chk("done_valid", 32'(mach_valid), 0);
        seq();
        brn(1'b0, 1);
        chk("frozen_pc", 32'(prog_ctr), HALT);
        chk("frozen_done", 32'(done), 1);

        // Mid-run reset clears everything, including the LUT
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        chk("mrst_pc", 32'(prog_ctr), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_issued", 32'(issued), 0);
        chk("mrst_valid", 32'(mach_valid), 0);
        chk("mrst_code", 32'(mach_code), 0);
        brn(1'b0, 1);
        chk("lut_cleared", 32'(prog_ctr), 0);
        brn(1'b1, 7);
        chk("rel_zero_loop", 32'(prog_ctr), 0);
        seq();
        chk("first_code", 32'(mach_code), 0);
        chk("first_valid", 32'(mach_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
